usb_dump_ctrl: RTL and testbench

Sequencer between the spectrum channel memory and the USB write port of the ISP1362 interface. On a fetch command it walks every channel address and reads each 32-bit count. It sends each count to the host as two 16-bit words, low word first, honouring the write-wait handshake. It also runs the memory clear sweep and holds the acquisition run/pause state decoded from host commands.

---
 rtl/usb_dump_ctrl.sv | 178 +++++++++++++++++
 tb/tb_usb_dump_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_dump_ctrl.sv
// Dump/clear sequencer between channel memory and ISP1362 USB write port.
// Optional trailing 16-bit checksum word enabled by `define USB_DUMP_CKSUM_EN.
module usb_dump_ctrl #(
  parameter int N_CH = 1024,
  parameter int AW   = 10
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          cmd_start,
  input  logic          cmd_pause,
  input  logic          cmd_fetch,
  input  logic          cmd_clear,
  input  logic [31:0]   channel_count,
  input  logic          usb_write_wait,
  output logic [AW-1:0] channel_address,
  output logic          mem_clr_we,
  output logic          acq_run,
  output logic [15:0]   usb_write_data,
  output logic          usb_write_en,
  output logic          busy,
  output logic          dump_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAT  = 3'd2,
    S_LSW  = 3'd3,
    S_MSW  = 3'd4,
    S_CKS  = 3'd5,
    S_DONE = 3'd6,
    S_CLR  = 3'd7
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_CH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic [15:0]   wdata_q;
  logic          wen_q;
  logic          clr_we_q;
  logic          busy_q;
  logic          done_q;
  logic          run_q;
`ifdef USB_DUMP_CKSUM_EN
  logic [15:0]   sum_q;
`endif

  // Sequencer: command decode, memory walk, two-word USB handshake and clear sweep.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= 32'd0;
      wdata_q  <= 16'd0;
      wen_q    <= 1'b0;
      clr_we_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      run_q    <= 1'b0;
`ifdef USB_DUMP_CKSUM_EN
      sum_q    <= 16'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_pause) begin
            run_q <= 1'b0;
          end else if (cmd_start) begin
            run_q <= 1'b1;
          end
          // Clear wins over a simultaneous fetch; the fetch is simply dropped.
          if (cmd_clear) begin
            state_q  <= S_CLR;
            addr_q   <= '0;
            clr_we_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (cmd_fetch) begin
            state_q <= S_RD;
            addr_q  <= '0;
            busy_q  <= 1'b1;
`ifdef USB_DUMP_CKSUM_EN
            sum_q   <= 16'd0;
`endif
          end
        end
        S_RD: begin
          wen_q   <= 1'b0;
          state_q <= S_LAT;
        end
        S_LAT: begin
          data_q  <= channel_count;
          state_q <= S_LSW;
        end
        S_LSW: begin
          if (!usb_write_wait) begin
            wdata_q <= data_q[15:0];
            wen_q   <= 1'b1;
`ifdef USB_DUMP_CKSUM_EN
            sum_q   <= sum_q + data_q[15:0];
`endif
            state_q <= S_MSW;
          end
        end
        S_MSW: begin
          // First cycle here only retires the low-word strobe.
          if (wen_q) begin
            wen_q <= 1'b0;
          end else if (!usb_write_wait) begin
            wdata_q <= data_q[31:16];
            wen_q   <= 1'b1;
`ifdef USB_DUMP_CKSUM_EN
            sum_q   <= sum_q + data_q[31:16];
`endif
            if (addr_q == LAST_ADDR) begin
`ifdef USB_DUMP_CKSUM_EN
              state_q <= S_CKS;
`else
              state_q <= S_DONE;
`endif
            end else begin
              addr_q  <= addr_q + ADDR_ONE;
              state_q <= S_RD;
            end
          end
        end
`ifdef USB_DUMP_CKSUM_EN
        S_CKS: begin
          if (wen_q) begin
            wen_q <= 1'b0;
          end else if (!usb_write_wait) begin
            wdata_q <= sum_q;
            wen_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          wen_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          addr_q  <= '0;
          state_q <= S_IDLE;
        end
        S_CLR: begin
          if (addr_q == LAST_ADDR) begin
            clr_we_q <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            addr_q <= addr_q + ADDR_ONE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          addr_q   <= '0;
          wen_q    <= 1'b0;
          clr_we_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign channel_address = addr_q;
  assign mem_clr_we      = clr_we_q;
  assign usb_write_data  = wdata_q;
  assign usb_write_en    = wen_q;
  assign busy            = busy_q;
  assign dump_done       = done_q;
  // Counting is frozen whenever the memory is being dumped or cleared.
  assign acq_run         = run_q & ~busy_q;

endmodule

// File: tb/tb_usb_dump_ctrl.sv
// Directed, table-driven bench for usb_dump_ctrl with a 4-channel memory model.
module tb_usb_dump_ctrl;

  localparam int N_CH = 4;
  localparam int AW   = 2;
`ifdef USB_DUMP_CKSUM_EN
  localparam int NW      = 2 * N_CH + 1;
  localparam int DONE_K  = 5 * N_CH + 3;
`else
  localparam int NW      = 2 * N_CH;
  localparam int DONE_K  = 5 * N_CH + 1;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          rst_n;
  logic          cmd_start, cmd_pause, cmd_fetch, cmd_clear;
  logic [31:0]   channel_count;
  logic          usb_write_wait;
  logic [AW-1:0] channel_address;
  logic          mem_clr_we, acq_run, usb_write_en, busy, dump_done;
  logic [15:0]   usb_write_data;

  usb_dump_ctrl #(.N_CH(N_CH), .AW(AW)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n),
    .cmd_start(cmd_start), .cmd_pause(cmd_pause),
    .cmd_fetch(cmd_fetch), .cmd_clear(cmd_clear),
    .channel_count(channel_count), .usb_write_wait(usb_write_wait),
    .channel_address(channel_address), .mem_clr_we(mem_clr_we),
    .acq_run(acq_run), .usb_write_data(usb_write_data),
    .usb_write_en(usb_write_en), .busy(busy), .dump_done(dump_done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] mem_word;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } dump_vec_t;

  typedef struct {
    logic start;
    logic pause;
    logic exp_run;
  } run_vec_t;

  dump_vec_t   dvec [N_CH];
  run_vec_t    rvec [7];
  logic [15:0] exp_words [NW];
  logic [31:0] mem [N_CH];
  logic        mem_load;

  // Synchronous-read channel memory; clear writes zero, load restores the table.
  always @(posedge CLOCK_50) begin
    channel_count <= mem[channel_address];
    if (mem_clr_we) mem[channel_address] <= 32'd0;
    else if (mem_load) for (int i = 0; i < N_CH; i++) mem[i] <= dvec[i].mem_word;
  end

  int total = 0;
  int bad   = 0;

  logic [15:0] words [$];
  int          ks [$];
  int          done_cnt, done_k, err_strobe, err_acq, timed_out;
  logic        acq_after;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge CLOCK_50); mem_load = 1'b1;
    @(negedge CLOCK_50); mem_load = 1'b0;
  endtask

  task automatic run_dump(input bit bp, input bit extra_fetch, input int stop_after);
    int k;
    bit prev_en, fin;
    words.delete(); ks.delete();
    done_cnt = 0; done_k = -1; err_strobe = 0; err_acq = 0; timed_out = 0; acq_after = 1'b0;
    @(negedge CLOCK_50); cmd_fetch = 1'b1;
    @(negedge CLOCK_50); cmd_fetch = 1'b0;
    chk("fetch_busy", {31'd0, busy}, 32'd1);
    chk("fetch_addr", {30'd0, channel_address}, 32'd0);
    k = 0; prev_en = 1'b0; fin = 1'b0;
    while (!fin) begin
      usb_write_wait = bp && ((k % 7) >= 2) && ((k % 7) <= 4);
      cmd_fetch = extra_fetch && (k == 4);
      @(negedge CLOCK_50);
      k++;
      if (usb_write_en) begin
        if (prev_en) err_strobe++;
        if (usb_write_wait) err_strobe++;
        words.push_back(usb_write_data);
        ks.push_back(k);
      end
      prev_en = usb_write_en;
      if (busy && acq_run) err_acq++;
      if (dump_done) begin
        done_cnt++; done_k = k; acq_after = acq_run; fin = 1'b1;
      end
      if (stop_after != 0 && words.size() >= stop_after) fin = 1'b1;
      if (k >= 400) begin timed_out = 1; fin = 1'b1; end
    end
    usb_write_wait = 1'b0;
    cmd_fetch = 1'b0;
    if (stop_after == 0) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge CLOCK_50);
        if (dump_done) done_cnt++;
        if (usb_write_en || busy) err_strobe++;
      end
    end
  endtask

  task automatic check_dump(input string tag);
    chk({tag, "_nwords"}, words.size(), NW);
    for (int i = 0; i < NW; i++) begin
      if (i < words.size()) chk({tag, "_word"}, {16'd0, words[i]}, {16'd0, exp_words[i]});
    end
    chk({tag, "_done_cnt"}, done_cnt, 32'd1);
    chk({tag, "_strobe_err"}, err_strobe, 32'd0);
    chk({tag, "_acq_busy"}, err_acq, 32'd0);
    chk({tag, "_timeout"}, timed_out, 32'd0);
  endtask

  task automatic run_clear(input bit with_fetch);
    int we_cnt, first_we, last_we, err;
    @(negedge CLOCK_50); cmd_clear = 1'b1; cmd_fetch = with_fetch;
    @(negedge CLOCK_50); cmd_clear = 1'b0; cmd_fetch = 1'b0;
    we_cnt = 0; first_we = -1; last_we = -1; err = 0;
    for (int k = 0; k < 12; k++) begin
      if (mem_clr_we) begin
        if (first_we < 0) first_we = k;
        last_we = k;
        if (channel_address != AW'(we_cnt)) err++;
        we_cnt++;
      end
      if (usb_write_en || dump_done) err++;
      @(negedge CLOCK_50);
    end
    chk("clr_we_cycles", we_cnt, 32'd4);
    chk("clr_first_we", first_we, 32'd0);
    chk("clr_contiguous", last_we - first_we, 32'd3);
    chk("clr_seq_err", err, 32'd0);
    chk("clr_busy_after", {31'd0, busy}, 32'd0);
    chk("clr_addr_after", {30'd0, channel_address}, 32'd0);
    for (int i = 0; i < N_CH; i++) chk("clr_mem_zero", mem[i], 32'd0);
  endtask

  initial begin
    logic [15:0] sum;
    dvec[0] = '{32'h0001_0002, 16'h0002, 16'h0001};
    dvec[1] = '{32'h0003_0004, 16'h0004, 16'h0003};
    dvec[2] = '{32'hFFFF_0000, 16'h0000, 16'hFFFF};
    dvec[3] = '{32'h1234_5678, 16'h5678, 16'h1234};
    rvec[0] = '{1'b1, 1'b1, 1'b0};
    rvec[1] = '{1'b1, 1'b0, 1'b1};
    rvec[2] = '{1'b0, 1'b0, 1'b1};
    rvec[3] = '{1'b1, 1'b1, 1'b0};
    rvec[4] = '{1'b1, 1'b0, 1'b1};
    rvec[5] = '{1'b0, 1'b1, 1'b0};
    rvec[6] = '{1'b1, 1'b0, 1'b1};
    sum = 16'd0;
    for (int i = 0; i < N_CH; i++) begin
      exp_words[2*i]   = dvec[i].exp_lo;
      exp_words[2*i+1] = dvec[i].exp_hi;
      sum = sum + dvec[i].exp_lo + dvec[i].exp_hi;
    end
`ifdef USB_DUMP_CKSUM_EN
    exp_words[NW-1] = sum;
`endif

    rst_n = 1'b0; cmd_start = 1'b0; cmd_pause = 1'b0; cmd_fetch = 1'b0;
    cmd_clear = 1'b0; usb_write_wait = 1'b0; mem_load = 1'b0;
    for (int i = 0; i < N_CH; i++) mem[i] = 32'd0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_outputs", {channel_address, mem_clr_we, acq_run, usb_write_data,
                        usb_write_en, busy, dump_done}, 32'd0);
    rst_n = 1'b1;
    load_mem();

    for (int i = 0; i < 7; i++) begin
      @(negedge CLOCK_50); cmd_start = rvec[i].start; cmd_pause = rvec[i].pause;
      @(negedge CLOCK_50); cmd_start = 1'b0; cmd_pause = 1'b0;
      chk("run_table", {31'd0, acq_run}, {31'd0, rvec[i].exp_run});
    end

    run_dump(1'b0, 1'b0, 0);
    check_dump("dump");
    chk("t_first_lsw", ks[0], 32'd3);
    chk("t_first_msw", ks[1], 32'd5);
    chk("t_second_lsw", ks[2], 32'd8);
    chk("t_done", done_k, DONE_K);
    chk("acq_after_done", {31'd0, acq_after}, 32'd1);

    run_dump(1'b1, 1'b0, 0);
    check_dump("bp");
    chk("bp_stretched", {31'd0, done_k > DONE_K}, 32'd1);

    run_dump(1'b0, 1'b1, 0);
    check_dump("ign_fetch");

    run_clear(1'b0);
    load_mem();
    run_clear(1'b1);
    load_mem();

    run_dump(1'b0, 1'b0, 3);
    chk("mid_words", words.size(), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {channel_address, mem_clr_we, acq_run, usb_write_data,
                            usb_write_en, busy, dump_done}, 32'd0);
    @(negedge CLOCK_50); rst_n = 1'b1;
    @(negedge CLOCK_50);
    chk("mid_rst_run_cleared", {31'd0, acq_run}, 32'd0);
    run_dump(1'b0, 1'b0, 0);
    check_dump("post_rst");
    chk("post_rst_first_lsw", ks[0], 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
